// File: rtl/nco_pkg.sv
// Shared definitions for the chirp-capable NCO: mode encoding, FSM states and
// the sample pipeline latency.
package nco_pkg;

    localparam logic MODE_CW  = 1'b0;
    localparam logic MODE_LFM = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } nco_state_t;

    // Registered stages between the phase accumulator and sine_out/cosine_out.
    localparam int NCO_LAT = 3;

endpackage

// File: rtl/nco_quarter_lut.sv
// Dual-read synchronous quarter-wave sine ROM holding unsigned magnitudes sampled
// at half-step offsets; its output register is stage 2 of the NCO pipeline.
module nco_quarter_lut
    import nco_pkg::*;
#(
    parameter int ADDR_BITS  = 10,
    parameter int DATA_WIDTH = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_BITS-3:0]    sin_addr,
    input  logic [ADDR_BITS-3:0]    cos_addr,
    output logic [DATA_WIDTH-2:0]   sin_mag,
    output logic [DATA_WIDTH-2:0]   cos_mag
);

    localparam int  QDEPTH = 1 << (ADDR_BITS - 2);
    localparam real PI     = 3.14159265358979323846;

    function automatic logic [DATA_WIDTH-2:0] lut_entry(input int i);
        real amp;
        real ph;
        amp = real'((1 << (DATA_WIDTH - 1)) - 1);
        ph  = 2.0 * PI * (real'(i) + 0.5) / real'(1 << ADDR_BITS);
        return (DATA_WIDTH-1)'($rtoi(amp * $sin(ph) + 0.5));
    endfunction

    logic [DATA_WIDTH-2:0] rom [QDEPTH];

    // NOTE: the ROM array is a constant table, so it is never reset; only the
    // read registers below carry reset, which keeps it mappable to block ROM.
    for (genvar i = 0; i < QDEPTH; i++) begin : g_rom
        assign rom[i] = lut_entry(i);
    end

    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples its inputs from before the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sin_mag <= '0;
            cos_mag <= '0;
        end else begin
            sin_mag <= rom[sin_addr];
            cos_mag <= rom[cos_addr];
        end
    end

endmodule

// File: rtl/nco_chirp_gen.sv
// Burst quadrature NCO: CW or linear-FM chirp of pulse_len samples with start
// phase, quarter-wave LUT folding and valid/last framing.
module nco_chirp_gen
    import nco_pkg::*;
#(
    parameter int PHASE_WIDTH = 32,
    parameter int ADDR_BITS   = 10,
    parameter int DATA_WIDTH  = 12,
    parameter int LEN_WIDTH   = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         stop,
    input  logic                         mode,
    input  logic [PHASE_WIDTH-1:0]       freq_start,
    input  logic [PHASE_WIDTH-1:0]       chirp_rate,
    input  logic [PHASE_WIDTH-1:0]       phase_offset,
    input  logic [LEN_WIDTH-1:0]         pulse_len,
    output logic                         busy,
    output logic                         out_valid,
    output logic                         out_last,
    output logic signed [DATA_WIDTH-1:0] sine_out,
    output logic signed [DATA_WIDTH-1:0] cosine_out
);

    localparam int IDX_BITS = ADDR_BITS - 2;

    nco_state_t state, state_nxt;

    logic                   mode_q;
    logic [PHASE_WIDTH-1:0] acc, inc, rate;
    logic [LEN_WIDTH-1:0]   cnt;
    logic                   launch;
    logic                   run_last;

    assign launch   = (state == IDLE) && start && !stop && (pulse_len != '0);
    assign run_last = (state == RUN) && (cnt == '0);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: next state defaults to the current state before the case, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (launch)   state_nxt = RUN;
            RUN:     if (run_last) state_nxt = DRAIN;
            DRAIN:   if (out_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (stop) state_nxt = IDLE;
    end

    // Phase/frequency generator; both accumulators wrap freely.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q <= MODE_CW;
            acc    <= '0;
            inc    <= '0;
            rate   <= '0;
            cnt    <= '0;
        end else if (launch) begin
            mode_q <= mode;
            acc    <= phase_offset;
            inc    <= freq_start;
            rate   <= chirp_rate;
            cnt    <= pulse_len - LEN_WIDTH'(1);
        end else if (state == RUN) begin
            acc <= acc + inc;
            if (mode_q == MODE_LFM) inc <= inc + rate;
            if (cnt != '0)          cnt <= cnt - LEN_WIDTH'(1);
        end
    end

    // Stage 1: quadrant and in-quadrant index of the current sample.
    logic                s1_valid, s1_last;
    logic [1:0]          s1_q;
    logic [IDX_BITS-1:0] s1_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_q     <= '0;
            s1_idx   <= '0;
        end else begin
            s1_valid <= (state == RUN) && !stop;
            s1_last  <= run_last && !stop;
            s1_q     <= acc[PHASE_WIDTH-1 -: 2];
            s1_idx   <= acc[PHASE_WIDTH-3 -: IDX_BITS];
        end
    end

    // Odd quadrants read the table mirrored; cosine is sine one quadrant ahead.
    logic [1:0]          cos_q;
    logic [IDX_BITS-1:0] sin_addr, cos_addr;

    assign cos_q    = s1_q + 2'd1;
    assign sin_addr = s1_q[0]  ? ~s1_idx : s1_idx;
    assign cos_addr = cos_q[0] ? ~s1_idx : s1_idx;

    // Stage 2: LUT read plus the sign of each output carried alongside.
    logic                  s2_valid, s2_last, s2_sin_neg, s2_cos_neg;
    logic [DATA_WIDTH-2:0] sin_mag, cos_mag;

    nco_quarter_lut #(
        .ADDR_BITS  (ADDR_BITS),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_lut (
        .clk      (clk),
        .rst      (rst),
        .sin_addr (sin_addr),
        .cos_addr (cos_addr),
        .sin_mag  (sin_mag),
        .cos_mag  (cos_mag)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid   <= 1'b0;
            s2_last    <= 1'b0;
            s2_sin_neg <= 1'b0;
            s2_cos_neg <= 1'b0;
        end else begin
            s2_valid   <= s1_valid && !stop;
            s2_last    <= s1_last && !stop;
            s2_sin_neg <= s1_q[1];
            s2_cos_neg <= cos_q[1];
        end
    end

    // Stage 3: apply sign; magnitudes never reach full scale, so negation is safe.
    logic signed [DATA_WIDTH-1:0] sin_s, cos_s;
    logic                         s3_take;

    assign sin_s   = {1'b0, sin_mag};
    assign cos_s   = {1'b0, cos_mag};
    assign s3_take = s2_valid && !stop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            sine_out   <= '0;
            cosine_out <= '0;
        end else begin
            out_valid  <= s3_take;
            out_last   <= s2_last && !stop;
            sine_out   <= !s3_take ? '0 : (s2_sin_neg ? -sin_s : sin_s);
            cosine_out <= !s3_take ? '0 : (s2_cos_neg ? -cos_s : cos_s);
        end
    end

endmodule

// File: doc/nco_chirp_gen.md
Name: nco_chirp_gen

Overview:
Parametrised successor to the team's free-running NCO. Generates a gated burst of `pulse_len` quadrature samples, either constant-frequency (CW) or linear-FM chirp, with a programmable start phase. Sine/cosine come from a single internal quarter-wave LUT with symmetry folding instead of a full-cycle ROM. Drives the pulse-compression reference/transmit path with valid/last framing.

Parameters:
PHASE_WIDTH, 32, phase accumulator and increment width
ADDR_BITS, 10, full-cycle LUT resolution; quarter LUT has 2^(ADDR_BITS-2) entries
DATA_WIDTH, 12, signed output width; peak amplitude 2^(DATA_WIDTH-1)-1
LEN_WIDTH, 16, pulse length counter width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
start  in  1  one-cycle request to begin a pulse; sampled only in IDLE
stop  in  1  synchronous abort; takes priority over start
mode  in  1  0 = CW, 1 = LFM; latched at start
freq_start  in  PHASE_WIDTH  initial phase increment; latched at start
chirp_rate  in  PHASE_WIDTH  added to the increment every sample in LFM (mod 2^PHASE_WIDTH); latched at start
phase_offset  in  PHASE_WIDTH  accumulator value for sample 0; latched at start
pulse_len  in  LEN_WIDTH  number of samples; latched at start
busy  out  1  high while a pulse is being generated or is still draining the pipeline
out_valid  out  1  sine_out/cosine_out hold a pulse sample
out_last  out  1  high with the final sample of the pulse
sine_out  out  DATA_WIDTH  signed sine sample
cosine_out  out  DATA_WIDTH  signed cosine sample

Behaviour:
- Reset: FSM = IDLE. Accumulator, increment, counter and all pipeline registers cleared. busy, out_valid, out_last = 0. sine_out = cosine_out = 0.
- FSM states:
  - IDLE: on edge E0 with start=1, stop=0 and pulse_len != 0, latch all inputs. acc <= phase_offset, inc <= freq_start, cnt <= pulse_len-1. Go to RUN. Start with pulse_len=0 is ignored.
  - RUN: each edge, acc <= acc+inc. In LFM only, inc <= inc+chirp_rate. When cnt=0 go to DRAIN; otherwise cnt <= cnt-1. Sample k is the acc value after edge E(k). Both acc and inc wrap modulo 2^PHASE_WIDTH with no saturation.
  - DRAIN: wait until the last sample exits the pipeline, then go to IDLE.
- Start while busy is ignored, so no queueing.
- Pipeline, 3 registered stages after acc:
  1. Address/quadrant register. addr = acc[MSB -: ADDR_BITS], q = addr[top 2], idx = remaining bits.
  2. LUT read of unsigned magnitudes for the sine and cosine indices.
  3. Sign/negate register.
- Sample k appears with out_valid=1 after edge E(k+3). out_last accompanies sample pulse_len-1.
- busy rises after E0 and falls after the edge following out_last.
- Folding, with LUT[i] = round((2^(DATA_WIDTH-1)-1)·sin(2π(i+0.5)/2^ADDR_BITS)):
  - sine: q0 LUT[idx], q1 LUT[~idx], q2 −LUT[idx], q3 −LUT[~idx].
  - cosine: same rule with quadrant q+1 mod 4.
  - Magnitude ≤ 2^(DATA_WIDTH-1)-1, so negation never overflows and the output never equals 0 or the most-negative code.
- Outputs are 0 whenever out_valid=0.
- stop=1 in any state: next edge FSM = IDLE, pipeline valid bits cleared, out_valid/out_last/busy = 0. Partial samples are discarded.
- stop and start on the same edge: stop wins.
- Reset mid-pulse: immediate return to reset values, with no output glitch beyond the asynchronous clear.

Decomposition:
- Shared package nco_pkg:
  - mode encoding constants MODE_CW=0, MODE_LFM=1
  - FSM state enum (IDLE, RUN, DRAIN)
  - pipeline latency constant NCO_LAT=3
- Sub-module nco_quarter_lut: dual-read synchronous quarter-wave ROM. Address ADDR_BITS-2, data DATA_WIDTH-1 unsigned, contents generated from the formula above. It also serves as stage 2 of the pipeline.

Test Plan (defaults; LUT[0]=6, LUT[255]=2047):
- CW, freq_start=0, phase_offset=0, pulse_len=4 → 4 valid samples, sine=6, cos=2047; out_last on the 4th; first out_valid 3 edges after E0.
- CW, freq_start=0x4000_0000, offset=0, len=4 → sine 6, 2047, −6, −2047; cos 2047, −6, −2047, 6.
- CW, freq_start=0, offset=0x8000_0000, len=2 → sine −6, cos −2047 (both samples).
- LFM, freq_start=0, chirp_rate=0x0100_0000, len=5 → addresses 0, 0, 4, 12, 24; sine = LUT[0], LUT[0], LUT[4], LUT[12], LUT[24]; busy low one edge after out_last.
- Boundaries:
  - start with pulse_len=0 → busy stays 0.
  - start pulsed during RUN → ignored, length unchanged.
  - offset=0xFFFF_FFFF, inc=1 → accumulator wraps to 0 cleanly.
- stop asserted at sample 2 of len=8 → next edge out_valid=0, busy=0, no out_last. Async rst mid-pulse → all outputs 0 immediately; a new start afterwards behaves as the first test.
